// File: rtl/dmas_pixel_scheduler_pkg.sv
// Shared definitions for the pixel scheduler: FSM encoding, sign codes
// and the sample/result widths used by the scheduler and its converter.
package dmas_pixel_scheduler_pkg;

    localparam int SAMPLE_W = 16;
    localparam int RESULT_W = 17;

    // Sign codes as seen by the external datapath (+1 / -1 in 2-bit two's complement)
    localparam logic [1:0] SIGN_POS = 2'b01;
    localparam logic [1:0] SIGN_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/dmas_pixel_scheduler_sign_mag_conv.sv
// Registered two's-complement to sign/magnitude converter.
// The most negative sample has no positive twin, so it saturates to the
// largest positive magnitude. When no sample is presented the magnitude
// is forced to zero while the sign keeps its previous value.
module sign_mag_conv
    import dmas_pixel_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_data,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] mag,
    output logic signed [1:0]          sign
);

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic                valid_reg;
    logic [SAMPLE_W-1:0] mag_reg;
    logic [1:0]          sign_reg;

    // One-cycle conversion register with sign hold on idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            mag_reg   <= '0;
            sign_reg  <= SIGN_POS;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                if (in_data == MOST_NEG) begin
                    mag_reg  <= MOST_POS;
                    sign_reg <= SIGN_NEG;
                end else if (in_data[SAMPLE_W-1]) begin
                    mag_reg  <= -in_data;
                    sign_reg <= SIGN_NEG;
                end else begin
                    mag_reg  <= in_data;
                    sign_reg <= SIGN_POS;
                end
            end else begin
                mag_reg <= '0;
            end
        end
    end

    assign out_valid = valid_reg;
    assign mag       = mag_reg;
    assign sign      = sign_reg;

endmodule

// File: rtl/dmas_pixel_scheduler.sv
// Per-pixel channel scheduler: streams CHANNELS samples out of the sample
// memory, converts them to sign/magnitude for the external datapath,
// waits for the datapath to settle, then presents the beamformed result
// on a ready/valid output before moving to the next pixel.
module dmas_pixel_scheduler
    import dmas_pixel_scheduler_pkg::*;
#(
    parameter int CHANNELS     = 128,
    parameter int CHANNEL_BITS = 8,
    parameter int PIXELS       = 1,
    parameter int PIXEL_BITS   = 8,
    parameter int DRAIN_CYCLES = 12
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       rd_en,
    output logic [CHANNEL_BITS-1:0]    rd_addr,
    output logic [PIXEL_BITS-1:0]      pix_idx,
    input  logic signed [SAMPLE_W-1:0] rd_data,
    output logic signed [SAMPLE_W-1:0] chnl_din,
    output logic signed [1:0]          sign,
    output logic                       ch_valid,
    output logic                       ch_last,
    output logic                       dp_clear,
    input  logic signed [RESULT_W-1:0] bf_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [RESULT_W-1:0] out_data,
    output logic                       done
);

    // DRAIN spans the cycle of the last read, the ch_last cycle and then
    // DRAIN_CYCLES counted cycles; the result is captured on the last one.
    localparam int                    DRAIN_W    = $clog2(DRAIN_CYCLES + 2);
    localparam logic [CHANNEL_BITS-1:0] CH_LAST  = CHANNEL_BITS'(CHANNELS - 1);
    localparam logic [PIXEL_BITS-1:0] PIX_LAST   = PIXEL_BITS'(PIXELS - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES + 1);

    state_t                    state_reg, state_next;
    logic [CHANNEL_BITS-1:0]   ch_cnt_reg, ch_cnt_next;
    logic [PIXEL_BITS-1:0]     pix_reg, pix_next;
    logic [DRAIN_W-1:0]        drain_reg, drain_next;
    logic [RESULT_W-1:0]       out_data_reg;
    logic                      rd_en_d1_reg;
    logic                      last_d1_reg;
    logic                      ch_last_reg;

    logic                      rd_en_next;
    logic                      rd_last;
    logic                      dp_clear_next;
    logic                      done_next;
    logic                      capture;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            ch_cnt_reg <= '0;
            pix_reg    <= '0;
            drain_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            ch_cnt_reg <= ch_cnt_next;
            pix_reg    <= pix_next;
            drain_reg  <= drain_next;
        end
    end

    // Next-state logic plus the strobes that belong to each transition
    always_comb begin
        state_next    = state_reg;
        ch_cnt_next   = ch_cnt_reg;
        pix_next      = pix_reg;
        drain_next    = drain_reg;
        rd_en_next    = 1'b0;
        dp_clear_next = 1'b0;
        done_next     = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = STREAM;
                    pix_next      = '0;
                    ch_cnt_next   = '0;
                    dp_clear_next = 1'b1;
                end
            end
            STREAM: begin
                rd_en_next = 1'b1;
                if (ch_cnt_reg == CH_LAST) begin
                    ch_cnt_next = '0;
                    drain_next  = '0;
                    state_next  = DRAIN;
                end else begin
                    ch_cnt_next = ch_cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    capture    = 1'b1;
                    drain_next = '0;
                    state_next = OUT;
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (pix_reg == PIX_LAST) begin
                        done_next  = 1'b1;
                        pix_next   = '0;
                        state_next = IDLE;
                    end else begin
                        dp_clear_next = 1'b1;
                        pix_next      = pix_reg + 1'b1;
                        state_next    = STREAM;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_last = rd_en_next && (ch_cnt_reg == CH_LAST);

    // Read-strobe delay to meet the memory's one-cycle read latency, and
    // ch_last pipeline kept aligned with the converter output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_d1_reg <= 1'b0;
            last_d1_reg  <= 1'b0;
            ch_last_reg  <= 1'b0;
        end else begin
            rd_en_d1_reg <= rd_en_next;
            last_d1_reg  <= rd_last;
            ch_last_reg  <= last_d1_reg;
        end
    end

    // Result capture at the end of the drain window; held through OUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg <= '0;
        end else if (capture) begin
            out_data_reg <= bf_in;
        end
    end

    sign_mag_conv u_conv (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en_d1_reg),
        .in_data   (rd_data),
        .out_valid (ch_valid),
        .mag       (chnl_din),
        .sign      (sign)
    );

    assign busy      = (state_reg != IDLE);
    assign rd_en     = rd_en_next;
    assign rd_addr   = ch_cnt_reg;
    assign pix_idx   = pix_reg;
    // start is combinational into dp_clear, so hold it low while in reset
    assign dp_clear  = dp_clear_next & rst;
    assign ch_last   = ch_last_reg;
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_data_reg;
    assign done      = done_next;

endmodule

// File: tb/tb_dmas_pixel_scheduler.sv
// Directed bench for dmas_pixel_scheduler: 4 channels, 3 pixels, short drain.
`timescale 1ns/1ps
module tb_dmas_pixel_scheduler;

    localparam int CHANNELS     = 4;
    localparam int CHANNEL_BITS = 8;
    localparam int PIXELS       = 3;
    localparam int PIXEL_BITS   = 8;
    localparam int DRAIN_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic busy, rd_en, ch_valid, ch_last, dp_clear, out_valid, done;
    logic [CHANNEL_BITS-1:0] rd_addr;
    logic [PIXEL_BITS-1:0]   pix_idx;
    logic signed [15:0]      rd_data = '0;
    logic signed [15:0]      chnl_din;
    logic signed [1:0]       sign;
    logic signed [16:0]      bf_in;
    logic signed [16:0]      out_data;
    logic [31:0]             cyc = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem_tbl [4];
    logic [31:0] exp_mag [4];
    logic [31:0] exp_sgn [4];

    dmas_pixel_scheduler #(
        .CHANNELS     (CHANNELS),
        .CHANNEL_BITS (CHANNEL_BITS),
        .PIXELS       (PIXELS),
        .PIXEL_BITS   (PIXEL_BITS),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .pix_idx   (pix_idx),
        .rd_data   (rd_data),
        .chnl_din  (chnl_din),
        .sign      (sign),
        .ch_valid  (ch_valid),
        .ch_last   (ch_last),
        .dp_clear  (dp_clear),
        .bf_in     (bf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Free-running cycle count doubles as the datapath result, so the
    // captured value pins down exactly which cycle was sampled.
    always @(posedge clk) cyc <= cyc + 1;
    assign bf_in = cyc[16:0];

    // Sample memory with one-cycle registered read
    always @(posedge clk) if (rd_en) rd_data <= mem_tbl[rd_addr[1:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_rd_en"},     32'(rd_en), 0);
        chk({tag, "_rd_addr"},   32'(rd_addr), 0);
        chk({tag, "_pix_idx"},   32'(pix_idx), 0);
        chk({tag, "_ch_valid"},  32'(ch_valid), 0);
        chk({tag, "_ch_last"},   32'(ch_last), 0);
        chk({tag, "_chnl_din"},  32'($unsigned(chnl_din)), 0);
        chk({tag, "_sign"},      32'($unsigned(sign)), 1);
        chk({tag, "_dp_clear"},  32'(dp_clear), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'($unsigned(out_data)), 0);
        chk({tag, "_done"},      32'(done), 0);
    endtask

    // Called at the negedge of the first STREAM cycle of pixel p.
    // Returns at the negedge after the OUT handshake.
    task automatic do_pixel(input int p, input int stall, input bit start_at_done);
        logic [31:0] last_cyc;
        logic [31:0] exp_data;
        int w;
        int idx;
        bit vld;
        out_ready = (stall == 0);
        last_cyc  = '0;
        for (int k = 0; k < 8; k++) begin
            vld = (k >= 2) && (k <= 5);
            idx = vld ? k - 2 : 0;
            chk("rd_en", 32'(rd_en), 32'(k < 4));
            if (k < 4) chk("rd_addr", 32'(rd_addr), k);
            chk("pix_idx", 32'(pix_idx), p);
            chk("busy", 32'(busy), 1);
            chk("dp_clear_quiet", 32'(dp_clear), 0);
            chk("ch_valid", 32'(ch_valid), 32'(vld));
            chk("ch_last", 32'(ch_last), 32'(k == 5));
            chk("chnl_din", 32'($unsigned(chnl_din)), vld ? exp_mag[idx] : 0);
            chk("sign", 32'($unsigned(sign)), vld ? exp_sgn[idx] : 1);
            if (k == 5) last_cyc = cyc;
            @(negedge clk);
        end
        w = 0;
        while (!out_valid && w < 40) begin
            chk("rd_en_drain", 32'(rd_en), 0);
            @(negedge clk);
            w++;
        end
        chk("out_valid_seen", 32'(out_valid), 1);
        chk("out_latency", cyc - last_cyc, DRAIN_CYCLES + 1);
        exp_data = last_cyc + DRAIN_CYCLES;
        for (int s = 0; s < stall; s++) begin
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data", 32'($unsigned(out_data)), exp_data);
            chk("stall_rd_en", 32'(rd_en), 0);
            chk("stall_done", 32'(done), 0);
            chk("stall_dp_clear", 32'(dp_clear), 0);
            @(negedge clk);
        end
        if (stall > 0) begin
            out_ready = 1'b1;
            #1;
        end
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'($unsigned(out_data)), exp_data);
        if (p < PIXELS - 1) begin
            chk("hs_dp_clear", 32'(dp_clear), 1);
            chk("hs_done", 32'(done), 0);
        end else begin
            chk("hs_done", 32'(done), 1);
            chk("hs_dp_clear", 32'(dp_clear), 0);
        end
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        chk("post_out_valid", 32'(out_valid), 0);
        if (p < PIXELS - 1) begin
            chk("next_busy", 32'(busy), 1);
            chk("next_rd_en", 32'(rd_en), 1);
            chk("next_rd_addr", 32'(rd_addr), 0);
            chk("next_pix_idx", 32'(pix_idx), p + 1);
        end else begin
            chk("end_busy", 32'(busy), 0);
            chk("end_pix_idx", 32'(pix_idx), 0);
            chk("end_done", 32'(done), 0);
        end
        $display("pixel %0d: out_data=0x%0h stall=%0d", p, exp_data, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_tbl[0] = 16'h0005;  exp_mag[0] = 32'd5;     exp_sgn[0] = 32'd1;
        mem_tbl[1] = 16'hFFF9;  exp_mag[1] = 32'd7;     exp_sgn[1] = 32'd3;
        mem_tbl[2] = 16'h8000;  exp_mag[2] = 32'd32767; exp_sgn[2] = 32'd3;
        mem_tbl[3] = 16'h0000;  exp_mag[3] = 32'd0;     exp_sgn[3] = 32'd1;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Frame A: start pulse, pixel 1 stalled 10 cycles, start in done cycle
        start = 1'b1; #1;
        chk("A_start_dp_clear", 32'(dp_clear), 1);
        chk("A_start_busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        do_pixel(0, 0, 1'b0);
        do_pixel(1, 10, 1'b0);
        do_pixel(2, 0, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("A_idle_busy", 32'(busy), 0);
            chk("A_idle_rd_en", 32'(rd_en), 0);
        end
        $display("frame A complete");

        // Frame B: start held high for the whole frame
        start = 1'b1; #1;
        chk("B_start_dp_clear", 32'(dp_clear), 1);
        @(negedge clk);
        do_pixel(0, 0, 1'b0);
        do_pixel(1, 0, 1'b0);
        do_pixel(2, 0, 1'b0);
        chk("B_restart_dp_clear", 32'(dp_clear), 1);
        @(negedge clk);
        start = 1'b0;
        $display("frame B complete");

        // Frame C: abandoned by reset at channel 2 of pixel 1
        do_pixel(0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("C_pre_rd_addr", 32'(rd_addr), 2);
        chk("C_pre_pix_idx", 32'(pix_idx), 1);
        chk("C_pre_ch_valid", 32'(ch_valid), 1);
        rst = 1'b0; #1;
        chk_reset_values("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("C_after_busy", 32'(busy), 0);
        chk("C_after_done", 32'(done), 0);
        $display("frame C abandoned by reset");

        // Frame D: clean frame after reset
        start = 1'b1; #1;
        chk("D_start_dp_clear", 32'(dp_clear), 1);
        @(negedge clk);
        start = 1'b0;
        do_pixel(0, 0, 1'b0);
        do_pixel(1, 0, 1'b0);
        do_pixel(2, 0, 1'b0);
        $display("frame D complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmas_pixel_scheduler.md
DMAS_PIXEL_SCHEDULER -- requirements
Module: dmas_pixel_scheduler

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 128: channels per pixel.
REQ-002 The block SHALL have parameter CHANNEL_BITS, default 8: channel counter width, holding the value CHANNELS.
REQ-003 The block SHALL have parameter PIXELS, default 1: pixels per frame.
REQ-004 The block SHALL have parameter PIXEL_BITS, default 8: pixel counter width.
REQ-005 The block SHALL have parameter DRAIN_CYCLES, default 12: datapath latency from ch_last to a valid bf_in.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on its posedge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: frame start request.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port rd_en, output, 1 bit: sample-memory read strobe.
REQ-011 The block SHALL have port rd_addr, output, CHANNEL_BITS bits: channel index being read.
REQ-012 The block SHALL have port pix_idx, output, PIXEL_BITS bits: current pixel.
REQ-013 The block SHALL have port rd_data, input, signed 16 bits: sample, valid one cycle after rd_en.
REQ-014 The block SHALL have port chnl_din, output, signed 16 bits: sample magnitude to the datapath.
REQ-015 The block SHALL have port sign, output, signed 2 bits: 2'b01 = +1, 2'b11 = -1.
REQ-016 The block SHALL have port ch_valid, output, 1 bit: chnl_din/sign valid.
REQ-017 The block SHALL have port ch_last, output, 1 bit: final channel of the pixel.
REQ-018 The block SHALL have port dp_clear, output, 1 bit: one-cycle datapath accumulator clear.
REQ-019 The block SHALL have port bf_in, input, signed 17 bits: datapath beamformed result.
REQ-020 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-021 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-022 The block SHALL have port out_data, output, signed 17 bits: captured pixel result.
REQ-023 The block SHALL have port done, output, 1 bit: one-cycle pulse when the frame completes.

Function
REQ-024 The FSM SHALL have states IDLE, STREAM, DRAIN, OUT.
REQ-025 In IDLE, start=1 SHALL move the FSM to STREAM, set pix_idx=0, and pulse dp_clear in that same cycle.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 In STREAM, rd_en SHALL be 1 for exactly CHANNELS consecutive cycles, with rd_addr = 0..CHANNELS-1; the FSM SHALL then enter DRAIN.
REQ-028 Conversion latency SHALL be 2 cycles: rd_en at cycle t produces registered chnl_din, sign and ch_valid at t+2.
REQ-029 ch_last SHALL be high with the ch_valid of channel CHANNELS-1 only.
REQ-030 Sign/magnitude conversion: rd_data>=0 SHALL give chnl_din=rd_data, sign=2'b01; rd_data<0 SHALL give chnl_din=-rd_data, sign=2'b11.
REQ-031 rd_data=-32768 SHALL saturate to chnl_din=32767, sign=2'b11.
REQ-032 When ch_valid=0, chnl_din SHALL be 0 and sign SHALL hold its last value.
REQ-033 DRAIN SHALL count DRAIN_CYCLES cycles starting from the cycle after ch_last, capture bf_in into out_data on its final cycle, and then enter OUT.
REQ-034 In OUT, out_valid SHALL be 1 and out_data stable until out_valid&out_ready; no new reads SHALL occur while out_ready=0.
REQ-035 On the OUT handshake, if pix_idx<PIXELS-1: pix_idx SHALL increment, dp_clear SHALL pulse, and the FSM SHALL return to STREAM.
REQ-036 On the OUT handshake, if pix_idx=PIXELS-1: done SHALL pulse, pix_idx SHALL return to 0, and the FSM SHALL return to IDLE.
REQ-037 out_ready=1 on the first OUT cycle SHALL give a 1-cycle OUT state.
REQ-038 A start arriving in the same cycle as done SHALL be ignored.

Reset
REQ-039 rst=0 SHALL asynchronously force: state IDLE; counters 0; rd_en, ch_valid, ch_last, dp_clear, out_valid and done = 0; chnl_din=0; out_data=0; sign=2'b01.
REQ-040 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the first start after release SHALL begin at pixel 0, channel 0.

Structure
REQ-041 A shared package SHALL hold the state encoding, the sign constants SIGN_POS=2'b01 and SIGN_NEG=2'b11, and the sample width 16 / result width 17.
REQ-042 Sign/magnitude conversion SHALL be a sub-module named sign_mag_conv, registered, 1 cycle.
REQ-043 The datapath itself SHALL stay external.

Verification
REQ-044 CHANNELS=4, PIXELS=1, start pulse: rd_addr SHALL be 0,1,2,3 on 4 consecutive cycles; ch_valid SHALL follow 2 cycles later; ch_last SHALL be high on the 4th.
REQ-045 rd_data sequence 5, -7, -32768, 0 -> (chnl_din, sign) SHALL be (5,01), (7,11), (32767,11), (0,01).
REQ-046 PIXELS=3 with out_ready=1 -> 3 dp_clear pulses, pix_idx 0→1→2, 3 out_valid beats, 1 done, then IDLE.
REQ-047 out_ready held 0 for 10 cycles in OUT -> out_data SHALL stay stable, rd_en SHALL stay 0, and progress SHALL resume after out_ready=1.
REQ-048 rst=0 at channel 2 of pixel 1 -> all outputs SHALL reach reset values immediately; a following start SHALL give rd_addr=0 and pix_idx=0.
REQ-049 start held high throughout a frame -> exactly one frame SHALL run per IDLE entry; start asserted in the done cycle SHALL not launch a frame.
